eth_stats_counter: RTL and testbench



---
 rtl/eth_stats_pkg.sv | 17 +
 rtl/eth_stats_counter_if.sv | 13 +
 rtl/eth_frame_counter.sv | 134 +++++++++++++
 rtl/eth_stats_counter.sv | 50 +++++
 tb/tb_eth_stats_counter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/eth_stats_pkg.sv
// Shared types and widths for the Ethernet per-port statistics monitor.
package eth_stats_pkg;

  localparam int LEN_W = 16;
  localparam int CNT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    SKIP
  } fsm_state_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/eth_stats_counter_if.sv
// One 8-bit AXI-Stream beat bus as seen by a passive monitor.
interface eth_stats_counter_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tready, tlast, tuser);
  modport slave  (input  tdata, tvalid, tready, tlast, tuser);

endinterface

// File: rtl/eth_frame_counter.sv
// One direction's framing FSM, length/error tracker and byte/good/bad counters.
module eth_frame_counter
  import eth_stats_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     srst_i,
  eth_stats_counter_if.slave       strm,
  output logic [CNT_W-1:0]         bytes_o,
  output logic [CNT_W-1:0]         good_o,
  output logic [CNT_W-1:0]         bad_o
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME);

  fsm_state_t        state_q, state_d;
  logic              in_frame_q, in_frame_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  bad_q, bad_d;

  logic              beat;
  logic              commit;
  logic [LEN_W-1:0]  final_len;
  logic              final_err;
  logic              frame_bad;
  logic              unused_tdata;

  assign unused_tdata = ^strm.tdata;
  assign beat         = strm.tvalid & strm.tready;

  // A commit from IDLE is a one-byte frame, so only ACTIVE contributes history.
  always_comb begin
    final_len = sat_inc((state_q == ACTIVE) ? len_q : '0);
    final_err = ((state_q == ACTIVE) ? err_q : 1'b0) | strm.tuser;
    frame_bad = final_err | (final_len < MIN_L) | (final_len > MAX_L);
  end

  always_comb begin
    state_d    = state_q;
    in_frame_d = beat ? ~strm.tlast : in_frame_q;
    len_d      = len_q;
    err_d      = err_q;
    bytes_d    = bytes_q;
    good_d     = good_q;
    bad_d      = bad_q;
    commit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (in_frame_q) begin
            // Joining mid-frame: a tlast beat right now already ends that frame.
            if (!(beat && strm.tlast)) state_d = SKIP;
          end else if (beat) begin
            if (strm.tlast) begin
              commit = 1'b1;
            end else begin
              state_d = ACTIVE;
              len_d   = LEN_W'(1);
              err_d   = strm.tuser;
            end
          end
        end
      end
      ACTIVE: begin
        if (!enable_i) begin
          state_d = in_frame_d ? SKIP : IDLE;
        end else if (beat) begin
          if (strm.tlast) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            len_d = sat_inc(len_q);
            err_d = err_q | strm.tuser;
          end
        end
      end
      SKIP: begin
        if (beat && strm.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // All three counters move together so the register block sees a whole frame.
    if (commit) begin
      bytes_d = bytes_q + CNT_W'(final_len);
      good_d  = good_q + CNT_W'(!frame_bad);
      bad_d   = bad_q + CNT_W'(frame_bad);
    end

    if (srst_i) begin
      state_d    = IDLE;
      in_frame_d = 1'b0;
      len_d      = '0;
      err_d      = 1'b0;
      bytes_d    = '0;
      good_d     = '0;
      bad_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_frame_q <= 1'b0;
      len_q      <= '0;
      err_q      <= 1'b0;
      bytes_q    <= '0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      len_q      <= len_d;
      err_q      <= err_d;
      bytes_q    <= bytes_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign bytes_o = bytes_q;
  assign good_o  = good_q;
  assign bad_o   = bad_q;

endmodule

// File: rtl/eth_stats_counter.sv
// Passive TX/RX frame statistics monitor for one Ethernet MAC port.
module eth_stats_counter
  import eth_stats_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 srst,
  eth_stats_counter_if.slave   tx,
  eth_stats_counter_if.slave   rx,
  output logic [CNT_W-1:0]     tx_bytes,
  output logic [CNT_W-1:0]     tx_good,
  output logic [CNT_W-1:0]     tx_bad,
  output logic [CNT_W-1:0]     rx_bytes,
  output logic [CNT_W-1:0]     rx_good,
  output logic [CNT_W-1:0]     rx_bad
);

  eth_frame_counter #(
    .MIN_FRAME (MIN_FRAME),
    .MAX_FRAME (MAX_FRAME)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .srst_i   (srst),
    .strm     (tx),
    .bytes_o  (tx_bytes),
    .good_o   (tx_good),
    .bad_o    (tx_bad)
  );

  eth_frame_counter #(
    .MIN_FRAME (MIN_FRAME),
    .MAX_FRAME (MAX_FRAME)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .srst_i   (srst),
    .strm     (rx),
    .bytes_o  (rx_bytes),
    .good_o   (rx_good),
    .bad_o    (rx_bad)
  );

endmodule

// File: tb/tb_eth_stats_counter.sv
// Directed-vector bench for eth_stats_counter with hand-computed counter values.
module tb_eth_stats_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        srst;
  logic [63:0] tx_bytes, tx_good, tx_bad;
  logic [63:0] rx_bytes, rx_good, rx_bad;

  int vecCount  = 0;
  int missCount = 0;

  eth_stats_counter_if tx_if ();
  eth_stats_counter_if rx_if ();

  always #5 clk = ~clk;

  eth_stats_counter #(
    .MIN_FRAME (64),
    .MAX_FRAME (1518)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .srst     (srst),
    .tx       (tx_if),
    .rx       (rx_if),
    .tx_bytes (tx_bytes),
    .tx_good  (tx_good),
    .tx_bad   (tx_bad),
    .rx_bytes (rx_bytes),
    .rx_good  (rx_good),
    .rx_bad   (rx_bad)
  );

  task automatic idleCycle();
    @(negedge clk);
    tx_if.tvalid = 1'b0; tx_if.tlast = 1'b0; tx_if.tuser = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
  endtask

  task automatic txBeat(input bit last, input bit user);
    @(negedge clk);
    tx_if.tvalid = 1'b1; tx_if.tready = 1'b1; tx_if.tlast = last; tx_if.tuser = user;
    tx_if.tdata  = 8'($urandom);
    rx_if.tvalid = 1'b0;
  endtask

  task automatic rxBeat(input bit last, input bit user);
    @(negedge clk);
    rx_if.tvalid = 1'b1; rx_if.tready = 1'b1; rx_if.tlast = last; rx_if.tuser = user;
    rx_if.tdata  = 8'($urandom);
    tx_if.tvalid = 1'b0;
  endtask

  task automatic bothBeat(input bit last);
    @(negedge clk);
    tx_if.tvalid = 1'b1; tx_if.tready = 1'b1; tx_if.tlast = last; tx_if.tuser = 1'b0;
    rx_if.tvalid = 1'b1; rx_if.tready = 1'b1; rx_if.tlast = last; rx_if.tuser = 1'b0;
  endtask

  task automatic sendTx(input int len, input int errByte);
    for (int i = 1; i <= len; i++) txBeat(i == len, i == errByte);
    idleCycle();
  endtask

  task automatic pulseSrst();
    idleCycle();
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; srst = 1'b0;
    tx_if.tvalid = 1'b0; tx_if.tready = 1'b0; tx_if.tlast = 1'b0; tx_if.tuser = 1'b0; tx_if.tdata = '0;
    rx_if.tvalid = 1'b0; rx_if.tready = 1'b0; rx_if.tlast = 1'b0; rx_if.tuser = 1'b0; rx_if.tdata = '0;
    repeat (3) @(negedge clk);
    vecCount++; if (tx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL reset_tx_bytes got %0d expected 0", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL reset_tx_good got %0d expected 0", tx_good); end
    vecCount++; if (tx_bad   !== 64'd0) begin missCount++; $display("[TB] FAIL reset_tx_bad got %0d expected 0", tx_bad); end
    vecCount++; if (rx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL reset_rx_bytes got %0d expected 0", rx_bytes); end
    vecCount++; if (rx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL reset_rx_good got %0d expected 0", rx_good); end
    vecCount++; if (rx_bad   !== 64'd0) begin missCount++; $display("[TB] FAIL reset_rx_bad got %0d expected 0", rx_bad); end
    rst_n = 1'b1;
  endtask

  // 64-byte good TX frame with a stalled (tready=0) beat carrying tlast/tuser inside it.
  task automatic test_tx_good();
    pulseSrst();
    for (int i = 1; i <= 63; i++) begin
      txBeat(1'b0, 1'b0);
      if (i == 20) begin
        @(negedge clk);
        tx_if.tready = 1'b0; tx_if.tlast = 1'b1; tx_if.tuser = 1'b1;
      end
    end
    txBeat(1'b1, 1'b0);
    vecCount++; if (tx_good !== 64'd0) begin missCount++; $display("[TB] FAIL tx_good_before_commit got %0d expected 0", tx_good); end
    idleCycle();
    vecCount++; if (tx_bytes !== 64'd64) begin missCount++; $display("[TB] FAIL tx_good_bytes got %0d expected 64", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL tx_good_good got %0d expected 1", tx_good); end
    vecCount++; if (tx_bad   !== 64'd0)  begin missCount++; $display("[TB] FAIL tx_good_bad got %0d expected 0", tx_bad); end
    vecCount++; if (rx_bytes !== 64'd0)  begin missCount++; $display("[TB] FAIL tx_good_rx_bytes got %0d expected 0", rx_bytes); end
    vecCount++; if (rx_good  !== 64'd0)  begin missCount++; $display("[TB] FAIL tx_good_rx_good got %0d expected 0", rx_good); end
  endtask

  // Runt then giant on RX with no gap between them.
  task automatic test_back_to_back();
    pulseSrst();
    vecCount++; if (tx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL srst_clears_tx_bytes got %0d expected 0", tx_bytes); end
    for (int i = 1; i <= 63; i++)   rxBeat(i == 63, 1'b0);
    for (int i = 1; i <= 1519; i++) rxBeat(i == 1519, 1'b0);
    idleCycle();
    vecCount++; if (rx_bytes !== 64'd1582) begin missCount++; $display("[TB] FAIL b2b_rx_bytes got %0d expected 1582", rx_bytes); end
    vecCount++; if (rx_good  !== 64'd0)    begin missCount++; $display("[TB] FAIL b2b_rx_good got %0d expected 0", rx_good); end
    vecCount++; if (rx_bad   !== 64'd2)    begin missCount++; $display("[TB] FAIL b2b_rx_bad got %0d expected 2", rx_bad); end
  endtask

  task automatic test_error_flag();
    pulseSrst();
    sendTx(100, 10);
    vecCount++; if (tx_bytes !== 64'd100) begin missCount++; $display("[TB] FAIL err_tx_bytes got %0d expected 100", tx_bytes); end
    vecCount++; if (tx_bad   !== 64'd1)   begin missCount++; $display("[TB] FAIL err_tx_bad got %0d expected 1", tx_bad); end
    vecCount++; if (tx_good  !== 64'd0)   begin missCount++; $display("[TB] FAIL err_tx_good got %0d expected 0", tx_good); end
  endtask

  task automatic test_enable_midframe();
    pulseSrst();
    enable = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      txBeat(i == 100, 1'b0);
      if (i == 30) enable = 1'b1;
    end
    sendTx(70, 0);
    vecCount++; if (tx_bytes !== 64'd70) begin missCount++; $display("[TB] FAIL en_on_bytes got %0d expected 70", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL en_on_good got %0d expected 1", tx_good); end
    vecCount++; if (tx_bad   !== 64'd0)  begin missCount++; $display("[TB] FAIL en_on_bad got %0d expected 0", tx_bad); end
    for (int i = 1; i <= 64; i++) begin
      txBeat(i == 64, 1'b0);
      if (i == 21) enable = 1'b0;
    end
    idleCycle();
    vecCount++; if (tx_bytes !== 64'd70) begin missCount++; $display("[TB] FAIL en_off_bytes got %0d expected 70", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL en_off_good got %0d expected 1", tx_good); end
    vecCount++; if (tx_bad   !== 64'd0)  begin missCount++; $display("[TB] FAIL en_off_bad got %0d expected 0", tx_bad); end
    enable = 1'b1;
    sendTx(64, 0);
    vecCount++; if (tx_bytes !== 64'd134) begin missCount++; $display("[TB] FAIL en_resume_bytes got %0d expected 134", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd2)   begin missCount++; $display("[TB] FAIL en_resume_good got %0d expected 2", tx_good); end
  endtask

  task automatic test_wrap();
    pulseSrst();
    force u_dut.u_tx.bytes_q = 64'hFFFF_FFFF_FFFF_FFF6;
    @(negedge clk);
    release u_dut.u_tx.bytes_q;
    vecCount++; if (tx_bytes !== 64'hFFFF_FFFF_FFFF_FFF6) begin missCount++; $display("[TB] FAIL wrap_preload got %0h expected fffffffffffffff6", tx_bytes); end
    sendTx(64, 0);
    vecCount++; if (tx_bytes !== 64'd54) begin missCount++; $display("[TB] FAIL wrap_bytes got %0d expected 54", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL wrap_good got %0d expected 1", tx_good); end
  endtask

  // Simultaneous TX/RX commits, then srst landing on the tlast beat.
  task automatic test_srst_on_tlast();
    pulseSrst();
    for (int i = 1; i <= 64; i++) bothBeat(i == 64);
    idleCycle();
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL dual_tx_good got %0d expected 1", tx_good); end
    vecCount++; if (rx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL dual_rx_good got %0d expected 1", rx_good); end
    vecCount++; if (rx_bytes !== 64'd64) begin missCount++; $display("[TB] FAIL dual_rx_bytes got %0d expected 64", rx_bytes); end
    for (int i = 1; i <= 64; i++) bothBeat(i == 64);
    srst = 1'b1;
    idleCycle();
    srst = 1'b0;
    vecCount++; if (tx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL srst_tlast_tx_bytes got %0d expected 0", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL srst_tlast_tx_good got %0d expected 0", tx_good); end
    vecCount++; if (rx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL srst_tlast_rx_bytes got %0d expected 0", rx_bytes); end
    vecCount++; if (rx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL srst_tlast_rx_good got %0d expected 0", rx_good); end
    idleCycle();
    vecCount++; if (tx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL srst_tlast_late_good got %0d expected 0", tx_good); end
  endtask

  task automatic test_rst_midframe();
    sendTx(64, 0);
    for (int i = 1; i <= 30; i++) txBeat(1'b0, 1'b0);
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
    vecCount++; if (tx_bytes !== 64'd0) begin missCount++; $display("[TB] FAIL rst_mid_bytes got %0d expected 0", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd0) begin missCount++; $display("[TB] FAIL rst_mid_good got %0d expected 0", tx_good); end
    sendTx(64, 0);
    vecCount++; if (tx_bytes !== 64'd64) begin missCount++; $display("[TB] FAIL rst_after_bytes got %0d expected 64", tx_bytes); end
    vecCount++; if (tx_good  !== 64'd1)  begin missCount++; $display("[TB] FAIL rst_after_good got %0d expected 1", tx_good); end
    vecCount++; if (tx_bad   !== 64'd0)  begin missCount++; $display("[TB] FAIL rst_after_bad got %0d expected 0", tx_bad); end
  endtask

  initial begin
    test_reset();
    test_tx_good();
    test_back_to_back();
    test_error_flag();
    test_enable_midframe();
    test_wrap();
    test_srst_on_tlast();
    test_rst_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
